// File: rtl/axi_pkg.sv
// Shared AXI response codes, burst length type and error-slave FSM states.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef logic [7:0] axi_len_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_err_slv_rd.sv
// Read burst generator for the AXI error slave: answers each AR with
// arlen+1 error beats and a correct rlast.
module axi_err_slv_rd
    import axi_pkg::*;
#(
    parameter int unsigned     AXI_ID_W   = 8,
    parameter int unsigned     AXI_DATA_W = 64,
    parameter logic [1:0]      RESP_CODE  = AXI_RESP_DECERR,
    parameter logic [AXI_DATA_W-1:0] RDATA_FILL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  arvalid,
    output logic                  arready,
    input  axi_len_t              arlen,
    input  logic [AXI_ID_W-1:0]   arid,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [AXI_ID_W-1:0]   rid,
    output logic [1:0]            rresp,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic                  rlast
);

    r_state_e              state_q, state_d;
    axi_len_t              cnt_q, cnt_d;
    logic [AXI_ID_W-1:0]   rid_q, rid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rid_d   = rid_q;
        unique case (state_q)
            R_IDLE: begin
                if (arready && arvalid) begin
                    rid_d   = arid;
                    cnt_d   = arlen;
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (cnt_q == '0) begin
                        state_d = R_IDLE;
                    end else begin
                        cnt_d = cnt_q - axi_len_t'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rid_q   <= rid_d;
        end
    end

    assign arready = en && (state_q == R_IDLE);
    assign rvalid  = (state_q == R_DATA);
    assign rlast   = rvalid && (cnt_q == '0);
    assign rid     = rvalid ? rid_q : '0;
    assign rresp   = rvalid ? RESP_CODE : 2'b00;
    assign rdata   = rvalid ? RDATA_FILL : '0;

endmodule

// File: rtl/axi_err_slv.sv
// AXI4 error/default slave: completes every write with one B and every
// read with arlen+1 R beats, all carrying RESP_CODE.
module axi_err_slv
    import axi_pkg::*;
#(
    parameter int unsigned     AXI_ID_W   = 8,
    parameter int unsigned     AXI_DATA_W = 64,
    parameter logic [1:0]      RESP_CODE  = AXI_RESP_DECERR,
    parameter logic [AXI_DATA_W-1:0] RDATA_FILL = {AXI_DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mst_awvalid,
    output logic                  mst_awready,
    input  logic [7:0]            mst_awlen,
    input  logic [AXI_ID_W-1:0]   mst_awid,
    input  logic                  mst_wvalid,
    output logic                  mst_wready,
    input  logic                  mst_wlast,
    output logic                  mst_bvalid,
    input  logic                  mst_bready,
    output logic [AXI_ID_W-1:0]   mst_bid,
    output logic [1:0]            mst_bresp,
    input  logic                  mst_arvalid,
    output logic                  mst_arready,
    input  logic [7:0]            mst_arlen,
    input  logic [AXI_ID_W-1:0]   mst_arid,
    output logic                  mst_rvalid,
    input  logic                  mst_rready,
    output logic [AXI_ID_W-1:0]   mst_rid,
    output logic [1:0]            mst_rresp,
    output logic [AXI_DATA_W-1:0] mst_rdata,
    output logic                  mst_rlast
);

    // Holds the address channels closed while rst is high and for the
    // edge that samples its release.
    logic en_q, en_d;

    w_state_e            w_state_q, w_state_d;
    logic [AXI_ID_W-1:0] bid_q, bid_d;

    logic unused_awlen;
    assign unused_awlen = ^mst_awlen;

    assign en_d = 1'b1;

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (mst_awready && mst_awvalid) begin
                    bid_d     = mst_awid;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (mst_wvalid && mst_wlast) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (mst_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            w_state_q <= W_IDLE;
            bid_q     <= '0;
        end else begin
            en_q      <= en_d;
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
        end
    end

    assign mst_awready = en_q && (w_state_q == W_IDLE);
    assign mst_wready  = (w_state_q == W_DATA);
    assign mst_bvalid  = (w_state_q == W_RESP);
    assign mst_bid     = mst_bvalid ? bid_q : '0;
    assign mst_bresp   = mst_bvalid ? RESP_CODE : 2'b00;

    axi_err_slv_rd #(
        .AXI_ID_W   (AXI_ID_W),
        .AXI_DATA_W (AXI_DATA_W),
        .RESP_CODE  (RESP_CODE),
        .RDATA_FILL (RDATA_FILL)
    ) u_rd (
        .clk     (clk),
        .rst     (rst),
        .en      (en_q),
        .arvalid (mst_arvalid),
        .arready (mst_arready),
        .arlen   (mst_arlen),
        .arid    (mst_arid),
        .rvalid  (mst_rvalid),
        .rready  (mst_rready),
        .rid     (mst_rid),
        .rresp   (mst_rresp),
        .rdata   (mst_rdata),
        .rlast   (mst_rlast)
    );

endmodule

// File: doc/axi_err_slv.md
Name: axi_err_slv

Overview:
Parametrised AXI4 error/default slave that terminates every transaction legally instead of stalling it. It sits on unmapped crossbar ports and as the decode-miss target. Every AW/W burst gets exactly one B response, and every AR gets arlen+1 R beats with correct rlast. Responses carry a configurable error code and ID echo.

Parameters:
AXI_ID_W, 8, ID width of aw/b/ar/r channels
AXI_DATA_W, 64, read data width
RESP_CODE, 2'b11 (DECERR), value driven on bresp/rresp for every response
RDATA_FILL, {AXI_DATA_W{1'b0}}, constant returned on rdata for every beat

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, synchronous, active-high
mst_awvalid  input  1  write address valid
mst_awready  output  1  write address ready
mst_awlen  input  8  burst length minus one (informational only)
mst_awid  input  AXI_ID_W  write ID
mst_wvalid  input  1  write data valid
mst_wready  output  1  write data ready
mst_wlast  input  1  final write beat
mst_bvalid  output  1  write response valid
mst_bready  input  1  write response ready
mst_bid  output  AXI_ID_W  echoed awid
mst_bresp  output  2  RESP_CODE when bvalid, else 0
mst_arvalid  input  1  read address valid
mst_arready  output  1  read address ready
mst_arlen  input  8  burst length minus one
mst_arid  input  AXI_ID_W  read ID
mst_rvalid  output  1  read data valid
mst_rready  input  1  read data ready
mst_rid  output  AXI_ID_W  echoed arid
mst_rresp  output  2  RESP_CODE when rvalid, else 0
mst_rdata  output  AXI_DATA_W  RDATA_FILL when rvalid, else 0
mst_rlast  output  1  final read beat

Behaviour:
- Address, wdata, wstrb and sideband signals (size/burst/lock/cache/prot/qos/region) are not ported. The integrating level leaves them unconnected.
- Reset: while rst=1, all outputs are 0, both FSMs go to IDLE, and ID regs and the beat counter clear. In the first cycle after release, awready=1 and arready=1.
- Write FSM W_IDLE/W_DATA/W_RESP, independent of read. All outputs are decoded from registered state/regs, with no input-to-output combinational path.
- W_IDLE: awready=1. On awvalid, capture awid and go to W_DATA.
- W_DATA: wready=1. Every beat is discarded. On wvalid&&wlast, go to W_RESP. Termination uses wlast only; awlen is not counted. W beats presented before AW are not accepted, since wready=0 outside W_DATA.
- W_RESP: bvalid=1 and bid=captured id. These hold stable until bready. On bready, go to W_IDLE. Latency: bvalid rises the cycle after the wlast handshake. The next AW is accepted one cycle after the B handshake.
- Read FSM R_IDLE/R_DATA.
  - R_IDLE: arready=1. On arvalid, capture arid, load the 8-bit counter with arlen, and go to R_DATA.
  - R_DATA: rvalid=1 and rlast=(cnt==0). On rready: if cnt==0, go to R_IDLE; otherwise decrement cnt.
  - First rvalid is the cycle after the AR handshake. arlen=255 gives 256 beats with no counter overflow. rid/rdata/rresp/rlast hold stable during rready stalls.
- One outstanding transaction per direction. AW and AR may handshake in the same cycle, and both channels then progress concurrently.
- rst asserted mid-burst or with B pending: the next cycle has all valids 0 and the transaction is dropped. No partial response follows after release.

Decomposition:
- Shared package axi_pkg holds the AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR 2-bit constants and the axi_len_t (8-bit) type. RESP_CODE defaults to AXI_RESP_DECERR.
- The read burst generator is a natural sub-module: axi_err_slv_rd, containing the R FSM and counter. The write path stays inline.

Test Plan:
- AW id=0x5A awlen=3, four W beats with wlast on the 4th, bready=1 -> awready drops after AW; bvalid=1 exactly one cycle after the 4th beat with bid=0x5A, bresp=2'b11, for one cycle.
- AR id=0x11 arlen=0, rready=1 -> single beat one cycle later: rvalid=1, rlast=1, rid=0x11, rresp=2'b11, rdata=RDATA_FILL; arready=1 again the following cycle.
- AR arlen=255 with rready toggling 1/0 each cycle -> exactly 256 accepted beats, rlast only on the 256th, outputs stable on stall cycles, no extra beat.
- Write burst with bready held 0 for 10 cycles -> bvalid/bid/bresp constant for all 10 cycles; awready=0 and wready=0 throughout; B completes on bready=1.
- AW id=0x3 and AR id=0x7 (arlen=3) in the same cycle, then rst pulsed on read beat 2 -> both handshakes accepted together; the cycle after rst, rvalid=0 and bvalid=0; after release arready=1, awready=1, with no stale beats.
